// File: rtl/axis_result_packer.sv
// Egress width converter: splits one wide PE result word into sign- or zero-extended
// BUS_WIDTH beats, lane 0 first, and marks the last beat of each frame with tlast.
module axis_result_packer #(
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned LANE_WIDTH   = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
    parameter int unsigned IN_WIDTH     = LANE_WIDTH * KERNEL_SIZE,
    parameter int unsigned BUS_WIDTH    = 32,
    parameter int unsigned FLEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLEN_WIDTH-1:0] frame_len,
    input  logic                  signed_mode,
    input  logic [IN_WIDTH-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [BUS_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_done
);

    localparam int unsigned IDX_WIDTH = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_LANE = IDX_WIDTH'(KERNEL_SIZE - 1);

    typedef enum logic {
        StEmpty,
        StSend
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;
    logic                  sign_q, sign_d;
    logic                  last_word_q, last_word_d;
    logic [IDX_WIDTH-1:0]  lane_q, lane_d;
    logic [FLEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [FLEN_WIDTH-1:0] len_q, len_d;
    logic [BUS_WIDTH-1:0]  tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  frame_done_q, frame_done_d;

    logic                  beat_acc;
    logic                  word_fin;
    logic                  s_acc;
    logic [FLEN_WIDTH-1:0] eff_len;
    logic [FLEN_WIDTH-1:0] len_use;
    logic [LANE_WIDTH-1:0] lane_bits;

    // Combinational path from m_axis_tready lets the next word load with no bubble.
    assign s_axis_tready = !rst && ((state_q == StEmpty) ||
                                    (m_axis_tready && (lane_q == LAST_LANE)));

    assign m_axis_tvalid = (state_q == StSend);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_done    = frame_done_q;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        sign_d       = sign_q;
        last_word_d  = last_word_q;
        lane_d       = lane_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        tdata_d      = tdata_q;
        tlast_d      = 1'b0;
        frame_done_d = 1'b0;
        lane_bits    = '0;

        beat_acc = (state_q == StSend) && m_axis_tready;
        word_fin = beat_acc && (lane_q == LAST_LANE);
        s_acc    = s_axis_tvalid && s_axis_tready;
        eff_len  = (frame_len == '0) ? FLEN_WIDTH'(1) : frame_len;

        if (word_fin) begin
            word_cnt_d = last_word_q ? '0 : word_cnt_q + 1'b1;
        end

        // A word arriving alongside a finishing one sees the already-advanced count.
        len_use = (word_cnt_d == '0) ? eff_len : len_q;

        if (s_acc) begin
            state_d     = StSend;
            word_d      = s_axis_tdata;
            sign_d      = signed_mode;
            last_word_d = (word_cnt_d == len_use - 1'b1);
            lane_d      = '0;
            if (word_cnt_d == '0) begin
                len_d = eff_len;
            end
        end else if (word_fin) begin
            state_d = StEmpty;
        end else if (beat_acc) begin
            lane_d = lane_q + 1'b1;
        end

        lane_bits = LANE_WIDTH'(word_d >> (int'(lane_d) * LANE_WIDTH));
        if (sign_d) begin
            tdata_d = BUS_WIDTH'($signed(lane_bits));
        end else begin
            tdata_d = BUS_WIDTH'(lane_bits);
        end

        tlast_d      = (state_d == StSend) && last_word_d && (lane_d == LAST_LANE);
        frame_done_d = beat_acc && tlast_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEmpty;
            word_q       <= '0;
            sign_q       <= 1'b0;
            last_word_q  <= 1'b0;
            lane_q       <= '0;
            word_cnt_q   <= '0;
            len_q        <= FLEN_WIDTH'(1);
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            sign_q       <= sign_d;
            last_word_q  <= last_word_d;
            lane_q       <= lane_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_axis_result_packer.sv
// Scoreboard bench for axis_result_packer: expected beats are queued at word handshake
// and compared as the DUT emits them; stall stability and frame_done are checked too.
module tb_axis_result_packer;

    localparam int unsigned K  = 3;
    localparam int unsigned LW = 19;
    localparam int unsigned IW = 57;
    localparam int unsigned BW = 32;

    logic          clk;
    logic          rst;
    logic [15:0]   frame_len;
    logic          signed_mode;
    logic [IW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          frame_done;

    axis_result_packer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_len    (frame_len),
        .signed_mode  (signed_mode),
        .s_axis_tdata (s_data),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .m_axis_tdata (m_data),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tlast (m_last),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [BW:0] exp_q[$];   // {tlast, tdata}
    int mdl_cnt = 0;
    int mdl_len = 1;
    bit bp_en = 0;
    int fd_pulses = 0;
    int beat_count = 0;
    int beat_first = 0;
    int beat_last = 0;
    int hs_cyc = 0;

    function automatic logic [BW-1:0] ext(input logic [LW-1:0] l, input logic s);
        logic msb;
        msb = l[LW-1];
        return s ? {{(BW-LW){msb}}, l} : {{(BW-LW){1'b0}}, l};
    endfunction

    task automatic push_expected(input logic [IW-1:0] w, input logic sgn);
        bit last;
        if (mdl_cnt == 0) mdl_len = (frame_len == 0) ? 1 : int'(frame_len);
        last = (mdl_cnt == mdl_len - 1);
        for (int i = 0; i < K; i++) begin
            exp_q.push_back({last && (i == K - 1), ext(w[i*LW +: LW], sgn)});
        end
        mdl_cnt = last ? 0 : mdl_cnt + 1;
    endtask

    task automatic monitor();
        logic          prev_stall = 0;
        logic [BW-1:0] prev_data = '0;
        logic          prev_last = 0;
        logic          fd_exp = 0;
        logic [BW:0]   e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                fd_exp = 0;
            end else begin
                tests++;
                if (frame_done !== fd_exp) begin
                    fails++;
                    $display("FAIL frame_done @%0d: got %b want %b", cyc, frame_done, fd_exp);
                end
                fd_exp = 0;
                if (frame_done) fd_pulses++;
                if (prev_stall) begin
                    tests++;
                    if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                        fails++;
                        $display("FAIL stall_hold @%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                 cyc, m_valid, m_data, m_last, prev_data, prev_last);
                    end
                end
                if (m_valid && m_ready) begin
                    beat_count++;
                    if (beat_count == 1) beat_first = cyc;
                    beat_last = cyc;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat @%0d: got d=%h, want no beat", cyc, m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_data !== e[BW-1:0] || m_last !== e[BW]) begin
                            fails++;
                            $display("FAIL beat @%0d: got d=%h l=%b want d=%h l=%b",
                                     cyc, m_data, m_last, e[BW-1:0], e[BW]);
                        end
                        fd_exp = e[BW];
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic send_one(input logic [IW-1:0] w, input logic sgn, input bit push_model);
        bit ok = 0;
        s_data = w;
        signed_mode = sgn;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL send_timeout: got s_ready=0 for 200 cycles, want 1");
        end else begin
            if (push_model) push_expected(w, sgn);
            hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain_timeout: got %0d beats pending, want 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_drain: got m_valid=%b want 0", m_valid);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || frame_done !== 1'b0 || m_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b l=%b fd=%b d=%h want 0 0 0 0",
                     m_valid, m_last, frame_done, m_data);
        end
        tests++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_s_ready: got %b want 0", s_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_s_ready: got %b want 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single(input logic sgn);
        logic [IW-1:0] w;
        int fd0;
        w = {19'h40000, 19'h7FFFF, 19'h00005};
        frame_len = 16'd1;
        fd0 = fd_pulses;
        if (sgn) begin
            exp_q.push_back({1'b0, 32'h0000_0005});
            exp_q.push_back({1'b0, 32'hFFFF_FFFF});
            exp_q.push_back({1'b1, 32'hFFFC_0000});
        end else begin
            exp_q.push_back({1'b0, 32'h0000_0005});
            exp_q.push_back({1'b0, 32'h0007_FFFF});
            exp_q.push_back({1'b1, 32'h0004_0000});
        end
        beat_count = 0;
        send_one(w, sgn, 0);
        drain();
        tests++;
        if (beat_count != 3 || beat_last - beat_first != 2) begin
            fails++;
            $display("FAIL single_timing: got %0d beats over %0d cycles, want 3 over 2",
                     beat_count, beat_last - beat_first);
        end
        tests++;
        if (fd_pulses - fd0 != 1) begin
            fails++;
            $display("FAIL single_frame_done: got %0d pulses want 1", fd_pulses - fd0);
        end
    endtask

    task automatic test_back_to_back();
        int hs[4];
        bit ok;
        frame_len = 16'd2;
        beat_count = 0;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_data = rand_word();
            signed_mode = 1'($urandom_range(0, 1));
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1;
                    break;
                end
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL b2b_timeout: word %0d got s_ready=0, want 1", k);
            end else begin
                push_expected(s_data, signed_mode);
            end
            hs[k] = cyc;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        drain();
        for (int k = 1; k < 4; k++) begin
            tests++;
            if (hs[k] - hs[k-1] != K) begin
                fails++;
                $display("FAIL b2b_accept_spacing: word %0d got %0d cycles want %0d",
                         k, hs[k] - hs[k-1], K);
            end
        end
        tests++;
        if (beat_count != 12 || beat_last - beat_first != 11) begin
            fails++;
            $display("FAIL b2b_gapless: got %0d beats over %0d cycles want 12 over 11",
                     beat_count, beat_last - beat_first);
        end
    endtask

    task automatic test_backpressure();
        frame_len = 16'd3;
        bp_en = 1;
        for (int k = 0; k < 3; k++) send_one(rand_word(), 1'($urandom_range(0, 1)), 1);
        drain();
        bp_en = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame_len_zero();
        frame_len = 16'd0;
        for (int k = 0; k < 3; k++) send_one(rand_word(), 1'b1, 1);
        drain();
    endtask

    task automatic test_frame_len_change();
        frame_len = 16'd3;
        send_one(rand_word(), 1'b0, 1);
        frame_len = 16'd1;
        for (int k = 0; k < 3; k++) send_one(rand_word(), 1'b1, 1);
        drain();
    endtask

    task automatic test_reset_mid_word();
        frame_len = 16'd2;
        send_one(rand_word(), 1'b1, 1);
        send_one(rand_word(), 1'b1, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        mdl_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || m_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_word: got v=%b l=%b want 0 0", m_valid, m_last);
        end
        @(posedge clk);
        #1;
        send_one(rand_word(), 1'b0, 1);
        send_one(rand_word(), 1'b0, 1);
        drain();
    endtask

    initial begin
        rst = 1'b1;
        frame_len = 16'd1;
        signed_mode = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        fork
            monitor();
            ready_driver();
        join_none
        test_reset();
        test_single(1'b1);
        test_single(1'b0);
        test_back_to_back();
        test_backpressure();
        test_frame_len_zero();
        test_frame_len_change();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_result_packer.md
Name: axis_result_packer

Overview:
- Egress width converter between the output FIFO of the PE datapath and the 32-bit AXI-Stream master toward the DMA.
- It is the transmit-side counterpart of the ingress data accumulator, which packs 32-bit beats into a full row.
- Accepts one wide PE result word (KERNEL_SIZE lanes of LANE_WIDTH bits) and emits one BUS_WIDTH beat per lane, sign- or zero-extended, lane 0 first.
- Generates m_axis_tlast at the end of each frame of frame_len result words.

Parameters:
- KERNEL_SIZE, 3, number of lanes per result word
- DATA_WIDTH, 8, pixel width
- WEIGHT_WIDTH, 8, weight width
- LANE_WIDTH, DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE (19), bits per PE output lane; must be ≤ BUS_WIDTH
- IN_WIDTH, LANE_WIDTH*KERNEL_SIZE (57), input word width
- BUS_WIDTH, 32, output beat width
- FLEN_WIDTH, 16, width of frame_len

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- frame_len  in  FLEN_WIDTH  result words per frame; 0 is treated as 1
- signed_mode  in  1  1 = sign-extend lanes, 0 = zero-extend
- s_axis_tdata  in  IN_WIDTH  result word; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH]
- s_axis_tvalid  in  1  word valid
- s_axis_tready  out  1  word accepted when tvalid & tready
- m_axis_tdata  out  BUS_WIDTH  extended lane
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of frame
- frame_done  out  1  one-cycle pulse when the tlast beat is accepted

Behaviour:
- Reset (rst=1 at a clk edge) clears the following:
  - m_axis_tvalid=0, m_axis_tlast=0, frame_done=0, m_axis_tdata=0.
  - Holding register empty; lane_idx=0, word_cnt=0.
  - Any partially sent word is discarded.
- s_axis_tready is 0 while rst is high.
- States:
  - EMPTY: m_axis_tvalid=0, s_axis_tready=1.
    - A word is accepted: latch the word, signed_mode and the last-word flag; lane_idx=0; go to SEND.
  - SEND: m_axis_tvalid=1.
    - m_axis_tdata = lane[lane_idx], extended per the latched signed_mode.
    - Registered output: data and tvalid are stable until the beat is accepted.
- Beat accept (m_axis_tvalid & m_axis_tready):
  - If lane_idx < KERNEL_SIZE-1: lane_idx increments.
  - Otherwise the word is finished. If s_axis_tvalid is high in the same cycle, the next word is loaded with no bubble and the block stays in SEND. If not, go to EMPTY.
- s_axis_tready = EMPTY | (SEND & m_axis_tready & lane_idx==KERNEL_SIZE-1). This is a combinational path from m_axis_tready and is intentional.
- Throughput is KERNEL_SIZE beats per word with no idle cycles between words.
- Latency is 1 cycle from word accept to the first beat valid.
- frame_len sampling and word count:
  - frame_len is sampled when word_cnt==0 and a word is accepted. Changes mid-frame have no effect until the next frame.
  - word_cnt increments on each finished word.
  - On the finish of word index eff_len-1 (eff_len = max(frame_len,1)), word_cnt wraps to 0.
- m_axis_tlast = 1 only on beat lane_idx==KERNEL_SIZE-1 of the word where word_cnt==eff_len-1.
- frame_done pulses in the cycle after that beat is accepted.
- m_axis_tready low holds all output signals stable (AXI rule). m_axis_tvalid never drops without acceptance.
- Extension: bits [BUS_WIDTH-1:LANE_WIDTH] are either all lane MSB (signed) or all 0 (unsigned). When LANE_WIDTH==BUS_WIDTH there is no extension.
- A simultaneous rst and handshake: rst wins and nothing is counted.

Test Plan:
- Single word, signed: signed_mode=1, frame_len=1, word=57'h0100003FFFF80005 (lanes 0x00005, 0x7FFFF, 0x40000), m_axis_tready=1.
  -> beats 0x00000005, 0xFFFFFFFF, 0xFFFC0000 on 3 consecutive cycles; tlast only on the 3rd beat; frame_done pulses once.
- Same word, unsigned: signed_mode=0.
  -> beats 0x00000005, 0x0007FFFF, 0x00040000.
- Back-to-back streaming: 4 words presented continuously, frame_len=2, tready=1.
  -> 12 beats with no gaps; tlast on beats 6 and 12; s_axis_tready high exactly on the cycles where word 2, 3 and 4 are accepted.
- Backpressure: m_axis_tready toggles 1,0,0,1... randomly during a 3-word frame.
  -> m_axis_tdata/tvalid/tlast stable while stalled; beat order and values identical to the unstalled run; no lost or duplicated words.
- frame_len edge cases:
  - frame_len=0 -> tlast on every 3rd beat.
  - frame_len changed 3→1 after word 1 of a 3-word frame -> tlast still after word 3; the next frame uses length 1.
- Reset mid-word: assert rst after beat 1 of a word.
  -> next cycle m_axis_tvalid=0, m_axis_tlast=0. The following word starts at lane 0 with word_cnt=0 (tlast after frame_len words counted from reset).
